// File: rtl/magic_buttons.sv
// Magic/Pause button conditioner: sync + debounce, press stretch to a frame strobe, long-Magic reset request (outputs registered, one clk28 after the accepted edge).
// Define MAGIC_BUTTONS_KBD_EN to add keyboard hotkey pulses (kbd_magic/kbd_pause) that set the pending flags directly.
module magic_buttons #(
    parameter int DEBOUNCE_TICKS = 16384,
    parameter int LONG_FRAMES    = 100
) (
    input  logic clk28,
    input  logic rst,
    input  logic ck35,
    input  logic n_int,
    input  logic n_int_next,
    input  logic magic_btn_n,
    input  logic pause_btn_n,
`ifdef MAGIC_BUTTONS_KBD_EN
    input  logic kbd_magic,
    input  logic kbd_pause,
`endif
    output logic magic_button,
    output logic pause_button,
    output logic reset_request
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int FW = $clog2(LONG_FRAMES + 1);
    localparam logic [CW-1:0] DB_LAST     = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [FW-1:0] FRAMES_MAX  = FW'(LONG_FRAMES);
    localparam logic [FW-1:0] FRAMES_LAST = FW'(LONG_FRAMES - 1);

    // Bit 0 is Magic, bit 1 is Pause throughout.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    pressed;
    logic [CW-1:0] db_cnt_q [2];
    logic [CW-1:0] db_cnt_d [2];
    logic [1:0]    stable_q, stable_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    btn_q, btn_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          req_q, req_d;
    logic          frame;
    logic [1:0]    kbd_set;

`ifdef MAGIC_BUTTONS_KBD_EN
    assign kbd_set = {kbd_pause, kbd_magic};
`else
    assign kbd_set = 2'b00;
`endif

    assign pressed = ~sync2_q;
    // Same qualifier the NMI controller uses, so a stretched press is always seen.
    assign frame   = n_int & ~n_int_next;

    always_comb begin
        stable_d = stable_q;
        pend_d   = pend_q;
        btn_d    = btn_q;
        db_cnt_d = db_cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (pressed[b] == stable_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (ck35) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = pressed[b];
                    db_cnt_d[b] = '0;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end

            if ((stable_d[b] & ~stable_q[b]) | kbd_set[b]) begin
                pend_d[b] = 1'b1;
            end else if (frame) begin
                pend_d[b] = 1'b0;
            end

            btn_d[b] = stable_d[b] | pend_d[b];
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        req_d       = 1'b0;
        if (!stable_q[0]) begin
            frame_cnt_d = '0;
        end else if (frame && (frame_cnt_q != FRAMES_MAX)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            req_d       = (frame_cnt_q == FRAMES_LAST);
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            stable_q    <= 2'b00;
            pend_q      <= 2'b00;
            btn_q       <= 2'b00;
            frame_cnt_q <= '0;
            req_q       <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= '0;
            end
        end else begin
            sync1_q     <= {pause_btn_n, magic_btn_n};
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            pend_q      <= pend_d;
            btn_q       <= btn_d;
            frame_cnt_q <= frame_cnt_d;
            req_q       <= req_d;
            for (int b = 0; b < 2; b++) begin
                db_cnt_q[b] <= db_cnt_d[b];
            end
        end
    end

    assign magic_button  = btn_q[0];
    assign pause_button  = btn_q[1];
    assign reset_request = req_q;

endmodule

// File: tb/tb_magic_buttons.sv
// Bench for magic_buttons: directed scenarios plus random pin activity against a behavioural model.
module tb_magic_buttons;

    localparam int DB = 4;
    localparam int LF = 3;

    logic clk28 = 1'b0;
    logic rst, ck35, n_int, n_int_next, magic_btn_n, pause_btn_n;
    logic magic_button, pause_button, reset_request;
    logic [1:0] kbd;

    always #5 clk28 = ~clk28;

    magic_buttons #(.DEBOUNCE_TICKS(DB), .LONG_FRAMES(LF)) dut (
        .clk28         (clk28),
        .rst           (rst),
        .ck35          (ck35),
        .n_int         (n_int),
        .n_int_next    (n_int_next),
        .magic_btn_n   (magic_btn_n),
        .pause_btn_n   (pause_btn_n),
`ifdef MAGIC_BUTTONS_KBD_EN
        .kbd_magic     (kbd[0]),
        .kbd_pause     (kbd[1]),
`endif
        .magic_button  (magic_button),
        .pause_button  (pause_button),
        .reset_request (reset_request)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames = 0;
    int req_pulses = 0;
    int req_at = 0;
    int f0 = 0;
    logic [1:0] pin_n;
    logic [1:0] seen_hi;
    logic [1:0] frame_out;

    // Reference model: pin history, accepted level, ticks of disagreement,
    // press-awaiting-strobe flag, frames held.
    logic m_p1 [2];
    logic m_p2 [2];
    logic m_stable [2];
    logic m_pend [2];
    logic m_out [2];
    int   m_dt [2];
    int   m_ft;
    logic m_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            m_p1[b] = 1'b1;
            m_p2[b] = 1'b1;
            m_stable[b] = 1'b0;
            m_pend[b] = 1'b0;
            m_out[b] = 1'b0;
            m_dt[b] = 0;
        end
        m_ft = 0;
        m_req = 1'b0;
    endfunction

    function automatic void model_step(input logic tick, input logic frame);
        logic seen, ns;
        m_req = 1'b0;
        if (!m_stable[0]) m_ft = 0;
        else if (frame && m_ft < LF) begin
            m_ft++;
            m_req = (m_ft == LF);
        end
        for (int b = 0; b < 2; b++) begin
            seen = !m_p2[b];
            ns = m_stable[b];
            if (seen == m_stable[b]) m_dt[b] = 0;
            else if (tick) begin
                m_dt[b]++;
                if (m_dt[b] == DB) begin
                    ns = seen;
                    m_dt[b] = 0;
                end
            end
            if ((ns && !m_stable[b]) || kbd[b]) m_pend[b] = 1'b1;
            else if (frame) m_pend[b] = 1'b0;
            m_out[b] = ns | m_pend[b];
            m_stable[b] = ns;
            m_p2[b] = m_p1[b];
            m_p1[b] = pin_n[b];
        end
    endfunction

    // Called at a negedge: check current outputs, then drive the next cycle.
    task automatic cycle();
        logic tick, frame;
        check_eq("magic_button", magic_button, m_out[0]);
        check_eq("pause_button", pause_button, m_out[1]);
        check_eq("reset_request", reset_request, m_req);
        if (magic_button) seen_hi[0] = 1'b1;
        if (pause_button) seen_hi[1] = 1'b1;
        if (reset_request) begin
            req_pulses++;
            req_at = frames;
        end
        cyc++;
        tick = (cyc % 8 == 0);
        n_int = n_int_next;
        n_int_next = (cyc % 200 != 0);
        frame = n_int && !n_int_next;
        ck35 = tick;
        magic_btn_n = pin_n[0];
        pause_btn_n = pin_n[1];
        if (frame) begin
            frames++;
            frame_out = {pause_button, magic_button};
        end
        model_step(tick, frame);
        @(negedge clk28);
        kbd = 2'b00;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_frames(input int n);
        int target;
        target = frames + n;
        while (frames < target) cycle();
    endtask

    task automatic run_to_phase(input int p);
        while ((cyc + 1) % 200 != p) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_magic", magic_button, 0);
        check_eq("rst_pause", pause_button, 0);
        check_eq("rst_req", reset_request, 0);
        model_reset();
        @(negedge clk28);
        @(negedge clk28);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ck35 = 1'b0;
        n_int = 1'b1;
        n_int_next = 1'b1;
        magic_btn_n = 1'b1;
        pause_btn_n = 1'b1;
        pin_n = 2'b11;
        kbd = 2'b00;
        seen_hi = 2'b00;
        frame_out = 2'b00;
        model_reset();
        repeat (3) @(negedge clk28);
        check_eq("reset_magic", magic_button, 0);
        check_eq("reset_pause", pause_button, 0);
        check_eq("reset_req", reset_request, 0);
        rst = 1'b0;
        run(20);

        // Bounce: three ticks of low level never gets accepted.
        run_to_phase(20);
        seen_hi = 2'b00;
        req_pulses = 0;
        pin_n[0] = 1'b0;
        run(24);
        pin_n[0] = 1'b1;
        run(100);
        check_eq("s1_bounce_out", seen_hi[0], 0);
        check_eq("s1_bounce_req", req_pulses, 0);

        // Short press released well before the strobe.
        run_to_phase(10);
        seen_hi = 2'b00;
        pin_n[0] = 1'b0;
        run(48);
        pin_n[0] = 1'b1;
        run_frames(1);
        check_eq("s2_pressed", seen_hi[0], 1);
        check_eq("s2_at_strobe", frame_out[0], 1);
        check_eq("s2_after_strobe", magic_button, 0);

        // Accepted edge lands on the strobe cycle itself.
        run_to_phase(170);
        pin_n[0] = 1'b0;
        run_frames(1);
        check_eq("s3_out_at_edge_strobe", frame_out[0], 0);
        check_eq("s3_edge_registered", magic_button, 1);
        pin_n[0] = 1'b1;
        run_frames(1);
        check_eq("s3_next_strobe", frame_out[0], 1);
        check_eq("s3_after_strobe", magic_button, 0);

        // Long press, then release and re-press.
        run_to_phase(50);
        req_pulses = 0;
        f0 = frames;
        pin_n[0] = 1'b0;
        run_frames(5);
        check_eq("s4_one_pulse", req_pulses, 1);
        check_eq("s4_third_strobe", req_at, f0 + 3);
        pin_n[0] = 1'b1;
        run(100);
        req_pulses = 0;
        f0 = frames;
        pin_n[0] = 1'b0;
        run_frames(4);
        check_eq("s4_repress_pulse", req_pulses, 1);
        check_eq("s4_repress_strobe", req_at, f0 + 3);
        pin_n[0] = 1'b1;
        run(300);

        // Reset while pressed and pending discards the press.
        run_to_phase(20);
        pin_n[0] = 1'b0;
        run(60);
        check_eq("s5_pressed_before_rst", magic_button, 1);
        pin_n[0] = 1'b1;
        magic_btn_n = 1'b1;
        do_reset();
        seen_hi = 2'b00;
        req_pulses = 0;
        run_frames(2);
        run(2);
        check_eq("s5_no_out_after_rst", seen_hi[0], 0);
        check_eq("s5_no_req_after_rst", req_pulses, 0);

        // Both buttons together.
        run_to_phase(20);
        pin_n = 2'b00;
        run(45);
        check_eq("s6_magic", magic_button, 1);
        check_eq("s6_pause", pause_button, 1);
        pin_n = 2'b11;
        run(250);
`ifdef MAGIC_BUTTONS_KBD_EN
        run_to_phase(20);
        kbd = 2'b10;
        run_frames(1);
        check_eq("s6_kbd_pause", frame_out[1], 1);
        check_eq("s6_kbd_magic_idle", frame_out[0], 0);
        check_eq("s6_kbd_after", pause_button, 0);
`endif

        // Random pin activity.
        for (int s = 0; s < 80; s++) begin
            pin_n[0] = 1'($urandom_range(0, 1));
            pin_n[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) do_reset();
`ifdef MAGIC_BUTTONS_KBD_EN
            if ($urandom_range(0, 5) == 0) kbd[$urandom_range(0, 1)] = 1'b1;
`endif
            if ($urandom_range(0, 9) == 0) run(int'($urandom_range(400, 700)));
            else run(int'($urandom_range(1, 90)));
        end
        pin_n = 2'b11;
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/magic_buttons.md
Name: magic_buttons

Overview:
- Input conditioner for the physical Magic and Pause buttons, sitting directly upstream of the magic/NMI controller.
- Synchronises and debounces the raw active-low pins.
- Stretches every debounced press so it is guaranteed to be high at one frame-interrupt edge, which is the only point where the controller samples it.
- Also detects a long Magic press and emits a one-cycle reset request.

Parameters:
DEBOUNCE_TICKS, 16384, ck35 enable ticks a raw level must stay stable before it is accepted (~4.7 ms)
LONG_FRAMES, 100, frame edges Magic must stay held to raise reset_request (~2 s at 50 Hz)

Ports:
clk28  input  1  system clock, 28 MHz
rst  input  1  asynchronous active-high reset
ck35  input  1  one-clk28-cycle 3.5 MHz enable strobe
n_int  input  1  current frame interrupt, active-low
n_int_next  input  1  registered-ahead frame interrupt, active-low
magic_btn_n  input  1  raw Magic pin, active-low, asynchronous
pause_btn_n  input  1  raw Pause pin, active-low, asynchronous
magic_button  output  1  conditioned Magic press, registered
pause_button  output  1  conditioned Pause press, registered
reset_request  output  1  one-cycle pulse on long Magic press

Behaviour:
- Reset: one clock, clk28; reset is asynchronous, active-high (rst).
  - Synchroniser flops reset to 1 (released).
  - Debounce counters, pending flags and frame counter reset to 0.
  - Stable states reset to released.
  - magic_button, pause_button and reset_request reset to 0.
  - Asserting rst mid-press discards the press completely; no output fires after release of rst until a new debounced press occurs.
- Synchronisation: 2-flop synchroniser per pin; the logic uses the inverted second stage (1 = pressed).
- Debounce, per button, identical for both:
  - Counter width is clog2(DEBOUNCE_TICKS).
  - If the synced level equals the stable state, the counter clears.
  - Otherwise the counter increments on each ck35.
  - On the ck35 where the counter equals DEBOUNCE_TICKS-1, the stable state takes the synced level and the counter clears.
  - Counter never wraps.
  - A glitch shorter than DEBOUNCE_TICKS ticks has no effect.
- Frame strobe: frame = n_int==1 && n_int_next==0. This is the exact condition the downstream controller samples on.
- Press stretch, per button:
  - Stable 0->1 transition sets pending.
  - A frame strobe clears pending.
  - Set wins if both occur in the same cycle.
  - Output register next value = stable | pending_next.
  - Consequence: the output is 1 in the cycle of at least one frame strobe after every debounced press, including a press whose edge coincides with a strobe.
  - Output stays 1 while held and falls the cycle after the first strobe following release (or immediately on release if no pending).
- Long press:
  - While Magic stable is pressed, the frame counter increments on each strobe, saturating at LONG_FRAMES.
  - reset_request pulses high for exactly one clk28 cycle on the strobe where the counter reaches LONG_FRAMES.
  - No repeat until release.
  - Stable release clears the counter.
  - Pause has no long-press function.
- Independence: the two buttons are fully independent. Simultaneous presses produce both outputs with no priority.

Optional Feature:
MAGIC_BUTTONS_KBD_EN
- Defined:
  - Adds inputs kbd_magic and kbd_pause (1 bit each), which are single-cycle pulses from the keyboard hotkey decoder, already synchronous to clk28.
  - A pulse sets the corresponding pending flag directly, bypassing debounce.
  - It obeys the same set-wins and strobe-clear rules.
  - It never contributes to the long-press counter.
- Undefined: the ports are absent and the pending flags are set only by debounced edges.

Test Plan:
(All scenarios use DEBOUNCE_TICKS=4, LONG_FRAMES=3, ck35 every 8 clk28, frame strobe every 200 clk28.)
1. Bounce rejection: magic_btn_n low for 3 ck35 ticks then high -> magic_button stays 0; no reset_request.
2. Short press: magic_btn_n low for 6 ticks, released well before the next strobe -> magic_button rises after the 4th tick, remains 1 through the next strobe cycle, and is 0 the cycle after.
3. Edge coincides with strobe: stable press edge lands exactly on a strobe cycle with instant release -> magic_button still 1 on the following strobe.
4. Long press: hold Magic across 5 strobes -> reset_request is high for exactly 1 cycle at the 3rd strobe and never again; after release and re-press it fires again after 3 more strobes.
5. Reset mid-press: assert rst while Magic is debounced-pressed and pending -> all outputs 0 immediately; release rst with pin released -> outputs stay 0 across 2 strobes.
6. Simultaneous buttons: both pins low for 6 ticks -> magic_button and pause_button both rise in the same cycle; with MAGIC_BUTTONS_KBD_EN, a kbd_pause pulse alone gives pause_button=1 through the next strobe.
